// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: word-aligned load for redirects, +PC_STEP increment after
// a delivered instruction, and a one-cycle misalignment flag for redirect targets.
module fetch_pc_reg #(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            misalign_q;
  logic            misalign_d;

  // Load wins over increment; the low two bits of a redirect target are dropped.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (load_i) begin
      pc_d       = {load_pc_i[XLEN-1:2], 2'b00};
      misalign_d = (load_pc_i[1:0] != 2'b00);
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(fetch_pkg::PC_STEP);
    end
  end

  // PC and misalignment flag registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word read at a time, holds the returned
// instruction for decode, and handles redirects by discarding stale responses.
module instr_fetch_unit #(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign_err
);

  fetch_pkg::fetch_state_t state_q;
  logic                    drop_q;
  logic [XLEN-1:0]         instr_out_q;
  logic [XLEN-1:0]         instr_pc_q;
  logic [XLEN-1:0]         pc_q;
  logic                    pc_inc;

  fetch_pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (redirect_valid),
    .load_pc_i  (redirect_pc),
    .inc_i      (pc_inc),
    .pc_o       (pc_q),
    .misalign_o (misalign_err)
  );

  // The PC advances only when a live (non-dropped) response is captured.
  always_comb begin
    pc_inc = 1'b0;
    if (!redirect_valid && (state_q == fetch_pkg::WAIT) && imem_rsp_valid && !drop_q) begin
      pc_inc = 1'b1;
    end
  end

  // Fetch FSM with drop flag and held-instruction registers; redirect has top priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= fetch_pkg::IDLE;
      drop_q      <= 1'b0;
      instr_out_q <= NOP_INSTR;
      instr_pc_q  <= '0;
    end else if (redirect_valid) begin
      case (state_q)
        fetch_pkg::IDLE: state_q <= fetch_pkg::IDLE;
        fetch_pkg::REQ: begin
          if (imem_req_ready) begin
            drop_q  <= 1'b1;
            state_q <= fetch_pkg::WAIT;
          end
        end
        fetch_pkg::WAIT: begin
          if (imem_rsp_valid) begin
            drop_q  <= 1'b0;
            state_q <= fetch_enable ? fetch_pkg::REQ : fetch_pkg::IDLE;
          end else begin
            drop_q <= 1'b1;
          end
        end
        fetch_pkg::HOLD: begin
          instr_out_q <= NOP_INSTR;
          state_q     <= fetch_enable ? fetch_pkg::REQ : fetch_pkg::IDLE;
        end
        default: state_q <= fetch_pkg::IDLE;
      endcase
    end else begin
      case (state_q)
        fetch_pkg::IDLE: begin
          if (fetch_enable) state_q <= fetch_pkg::REQ;
        end
        fetch_pkg::REQ: begin
          if (imem_req_ready) state_q <= fetch_pkg::WAIT;
        end
        fetch_pkg::WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= fetch_enable ? fetch_pkg::REQ : fetch_pkg::IDLE;
            end else begin
              instr_out_q <= imem_rsp_data;
              instr_pc_q  <= pc_q;
              state_q     <= fetch_pkg::HOLD;
            end
          end
        end
        fetch_pkg::HOLD: begin
          if (instr_ready) begin
            instr_out_q <= NOP_INSTR;
            state_q     <= fetch_enable ? fetch_pkg::REQ : fetch_pkg::IDLE;
          end
        end
        default: state_q <= fetch_pkg::IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == fetch_pkg::REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == fetch_pkg::HOLD);
  assign instr_out      = instr_out_q;
  assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: memory responder and decode monitor act as
// scoreboards against queues of expected request addresses and instructions.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        misalign_err;

  int total = 0;
  int bad = 0;
  int acceptCount = 0;
  int rspDelay = 0;
  logic [31:0] expAddrQ[$];
  logic [63:0] expInstrQ[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitHoldPc(input logic [31:0] pc, input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      tick();
      cycles++;
      if (instr_valid === 1'b1 && instr_pc === pc) ok = 1'b1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    fetch_enable = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic checkQueuesEmpty(input string name);
    total++;
    if (expAddrQ.size() != 0 || expInstrQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: pending addr=%0d instr=%0d, want 0/0", name, expAddrQ.size(), expInstrQ.size());
    end
    expAddrQ.delete();
    expInstrQ.delete();
  endtask

  // Memory model: checks each accepted address against the expected queue and replies after rspDelay+1 cycles.
  initial begin : responder
    logic [31:0] a;
    logic [31:0] e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!reset && imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        acceptCount++;
        total++;
        if (expAddrQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL req_addr: unexpected request got=%h want=none", a);
        end else begin
          e = expAddrQ.pop_front();
          if (a !== e) begin
            bad++;
            $display("[TB] FAIL req_addr: got=%h want=%h", a, e);
          end
        end
        @(posedge clk);
        repeat (rspDelay) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = memWord(a);
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
      end
    end
  end

  // Decode monitor: every consumed instruction must match the next expected {pc, instr}.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        total++;
        if (expInstrQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL delivery: unexpected pc=%h instr=%h want=none", instr_pc, instr_out);
        end else begin
          e = expInstrQ.pop_front();
          if ({instr_pc, instr_out} !== e) begin
            bad++;
            $display("[TB] FAIL delivery: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr_out, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    reset = 1'b1;
    #2;
    total++;
    if ({imem_req_valid, instr_valid, misalign_err} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got=%b want=000", {imem_req_valid, instr_valid, misalign_err});
    end
    total++;
    if (instr_out !== NOP) begin
      bad++;
      $display("[TB] FAIL reset_instr_out: got=%h want=%h", instr_out, NOP);
    end
    total++;
    if (instr_pc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_instr_pc: got=%h want=0", instr_pc);
    end
    total++;
    if (imem_req_addr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_pc: got=%h want=0", imem_req_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_no_req: got=%b want=0", imem_req_valid);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    int cyc;
    doReset();
    rspDelay = 0;
    for (int i = 0; i < 3; i++) begin
      expAddrQ.push_back(32'(i * 4));
      expInstrQ.push_back({32'(i * 4), memWord(32'(i * 4))});
    end
    fetch_enable = 1'b1;
    waitHoldPc(32'h8, 40, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL seq_reach_8: got timeout want hold at pc=8");
    end
    fetch_enable = 1'b0;
    tick();
    tick();
    total++;
    if ({imem_req_valid, instr_valid} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL seq_idle: got=%b want=00", {imem_req_valid, instr_valid});
    end
    checkQueuesEmpty("seq");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    doReset();
    rspDelay = 0;
    for (int i = 0; i < 3; i++) begin
      expAddrQ.push_back(32'(i * 4));
      expInstrQ.push_back({32'(i * 4), memWord(32'(i * 4))});
    end
    fetch_enable = 1'b1;
    waitHoldPc(32'h0, 20, ok, cyc);
    total++;
    if (!ok || cyc != 3) begin
      bad++;
      $display("[TB] FAIL b2b_first_latency: got ok=%0d cycles=%0d want ok=1 cycles=3", ok, cyc);
    end
    waitHoldPc(32'h4, 20, ok, cyc);
    total++;
    if (!ok || cyc != 3) begin
      bad++;
      $display("[TB] FAIL b2b_period_4: got ok=%0d cycles=%0d want ok=1 cycles=3", ok, cyc);
    end
    waitHoldPc(32'h8, 20, ok, cyc);
    total++;
    if (!ok || cyc != 3) begin
      bad++;
      $display("[TB] FAIL b2b_period_8: got ok=%0d cycles=%0d want ok=1 cycles=3", ok, cyc);
    end
    fetch_enable = 1'b0;
    tick();
    checkQueuesEmpty("b2b");
  endtask

  task automatic test_req_stall();
    bit ok;
    int cyc;
    int base;
    doReset();
    rspDelay = 0;
    base = acceptCount;
    expAddrQ.push_back(32'h0);
    expAddrQ.push_back(32'h4);
    expInstrQ.push_back({32'h0, memWord(32'h0)});
    expInstrQ.push_back({32'h4, memWord(32'h4)});
    fetch_enable = 1'b1;
    waitHoldPc(32'h0, 20, ok, cyc);
    imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin
        bad++;
        $display("[TB] FAIL stall_addr_%0d: got valid=%b addr=%h want valid=1 addr=4", i, imem_req_valid, imem_req_addr);
      end
      if (i < 3) tick();
    end
    imem_req_ready = 1'b1;
    waitHoldPc(32'h4, 20, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL stall_deliver: got timeout want hold at pc=4");
    end
    fetch_enable = 1'b0;
    tick();
    total++;
    if (acceptCount - base != 2) begin
      bad++;
      $display("[TB] FAIL stall_accepts: got=%0d want=2", acceptCount - base);
    end
    checkQueuesEmpty("stall");
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int cyc;
    int n;
    doReset();
    rspDelay = 2;
    expAddrQ.push_back(32'h0);
    expAddrQ.push_back(32'h4);
    expAddrQ.push_back(32'h8);
    expAddrQ.push_back(32'h100);
    expInstrQ.push_back({32'h0, memWord(32'h0)});
    expInstrQ.push_back({32'h4, memWord(32'h4)});
    expInstrQ.push_back({32'h100, memWord(32'h100)});
    fetch_enable = 1'b1;
    n = 0;
    while (!(imem_req_valid === 1'b1 && imem_req_addr === 32'h8) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("[TB] FAIL redir_reach_req8: got timeout want request at 8");
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({imem_req_valid, instr_valid, imem_req_addr} !== {2'b00, 32'h100}) begin
      bad++;
      $display("[TB] FAIL redir_wait_state: got req=%b iv=%b addr=%h want 0 0 100", imem_req_valid, instr_valid, imem_req_addr);
    end
    waitHoldPc(32'h100, 30, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL redir_deliver: got timeout want hold at pc=100");
    end
    fetch_enable = 1'b0;
    tick();
    rspDelay = 0;
    checkQueuesEmpty("redir");
  endtask

  task automatic test_misalign();
    bit ok;
    int cyc;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (misalign_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL misalign_aligned: got=%b want=0", misalign_err);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (misalign_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL misalign_pulse: got=%b want=1", misalign_err);
    end
    tick();
    total++;
    if ({misalign_err, imem_req_valid, imem_req_addr} !== {2'b00, 32'h200}) begin
      bad++;
      $display("[TB] FAIL misalign_after: got err=%b req=%b addr=%h want 0 0 200", misalign_err, imem_req_valid, imem_req_addr);
    end
    expAddrQ.push_back(32'h200);
    expInstrQ.push_back({32'h200, memWord(32'h200)});
    fetch_enable = 1'b1;
    waitHoldPc(32'h200, 20, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL misalign_deliver: got timeout want hold at pc=200");
    end
    fetch_enable = 1'b0;
    tick();
    checkQueuesEmpty("misalign");
  endtask

  task automatic test_hold_stall();
    bit ok;
    int cyc;
    doReset();
    instr_ready = 1'b0;
    expAddrQ.push_back(32'h0);
    fetch_enable = 1'b1;
    waitHoldPc(32'h0, 20, ok, cyc);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({instr_valid, instr_out, instr_pc} !== {1'b1, memWord(32'h0), 32'h0}) begin
        bad++;
        $display("[TB] FAIL hold_stable_%0d: got iv=%b instr=%h pc=%h want 1 %h 0", i, instr_valid, instr_out, instr_pc, memWord(32'h0));
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    fetch_enable = 1'b0;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({instr_valid, instr_out} !== {1'b0, NOP}) begin
      bad++;
      $display("[TB] FAIL hold_flush: got iv=%b instr=%h want 0 %h", instr_valid, instr_out, NOP);
    end
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h40}) begin
      bad++;
      $display("[TB] FAIL hold_flush_pc: got req=%b addr=%h want 0 40", imem_req_valid, imem_req_addr);
    end
    instr_ready = 1'b1;
    checkQueuesEmpty("hold");
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    doReset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    expAddrQ.push_back(32'hFFFF_FFFC);
    expInstrQ.push_back({32'hFFFF_FFFC, memWord(32'hFFFF_FFFC)});
    fetch_enable = 1'b1;
    waitHoldPc(32'hFFFF_FFFC, 20, ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL wrap_deliver: got timeout want hold at pc=fffffffc");
    end
    imem_req_ready = 1'b0;
    tick();
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL wrap_addr: got req=%b addr=%h want 1 0", imem_req_valid, imem_req_addr);
    end
    fetch_enable = 1'b0;
    checkQueuesEmpty("wrap");
  endtask

  task automatic test_reset_midwait();
    int n;
    doReset();
    rspDelay = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    expAddrQ.push_back(32'h80);
    fetch_enable = 1'b1;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tick();
    fetch_enable = 1'b0;
    reset = 1'b1;
    #2;
    total++;
    if ({imem_req_valid, instr_valid, imem_req_addr, instr_out} !== {2'b00, 32'h0, NOP}) begin
      bad++;
      $display("[TB] FAIL midwait_reset: got req=%b iv=%b addr=%h instr=%h want 0 0 0 %h", imem_req_valid, instr_valid, imem_req_addr, instr_out, NOP);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({imem_req_valid, instr_valid, instr_out} !== {2'b00, NOP}) begin
        bad++;
        $display("[TB] FAIL late_rsp_ignored_%0d: got req=%b iv=%b instr=%h want 0 0 %h", i, imem_req_valid, instr_valid, instr_out, NOP);
      end
    end
    rspDelay = 0;
    checkQueuesEmpty("midwait");
  endtask

  // Safety net so a stuck run still ends.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin : main
    $display("[TB] starting instr_fetch_unit tests");
    test_reset();
    test_sequential();
    test_back_to_back();
    test_req_stall();
    test_redirect_wait();
    test_misalign();
    test_hold_stall();
    test_wrap();
    test_reset_midwait();
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
